// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver.
// The PARITY state exists only when UART_RECV_PARITY_EN is defined.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_RECV_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } uart_rx_state_t;

   // Sample points relative to the bit centre M = BPS_CNT/2.
   localparam int SMP_EARLY_OFS = -1;
   localparam int SMP_MID_OFS   = 0;
   localparam int SMP_LATE_OFS  = 1;

   function automatic int bps_cnt(input int clk_freq, input int bps);
      return clk_freq / bps;
   endfunction

endpackage

// File: rtl/uart_recv_cfg_if.sv
// Valid/ready delivery channel of the UART receiver plus its per-word status flags.
interface uart_recv_cfg_if #(parameter int DATA_BITS = 8);
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_ready;
   logic                 rx_frame_err;
   logic                 rx_parity_err;
   logic                 rx_overrun;

   modport master (
      output rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun,
      input  rx_ready
   );

   modport slave (
      input  rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun,
      output rx_ready
   );
endinterface

// File: rtl/uart_rx_sync_filter.sv
// Line synchroniser, falling-edge detector and three-sample majority vote.
// bit_val is meaningful in the cycle where clk_cnt equals M+1.
module uart_rx_sync_filter
   import uart_pkg::*;
#(
   parameter int CNT_W = 9,
   parameter int M     = 217
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             uart_rxd,
   input  logic [CNT_W-1:0] clk_cnt,
   output logic             rxd_s,
   output logic             fall_edge,
   output logic             bit_val
);

   localparam logic [CNT_W-1:0] CNT_EARLY = CNT_W'(M + SMP_EARLY_OFS);
   localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(M + SMP_MID_OFS);

   logic sync_q1, sync_q2, rxd_prev;
   logic smp_early, smp_mid;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         sync_q1   <= 1'b1;
         sync_q2   <= 1'b1;
         rxd_prev  <= 1'b1;
         smp_early <= 1'b1;
         smp_mid   <= 1'b1;
      end else begin
         sync_q1  <= uart_rxd;
         sync_q2  <= sync_q1;
         rxd_prev <= sync_q2;
         if (clk_cnt == CNT_EARLY) smp_early <= sync_q2;
         if (clk_cnt == CNT_MID)   smp_mid   <= sync_q2;
      end
   end

   assign rxd_s     = sync_q2;
   assign fall_edge = rxd_prev & ~sync_q2;
   // Third sample is the live synchronised level at M+1.
   assign bit_val   = (smp_early & smp_mid) | (smp_early & sync_q2) | (smp_mid & sync_q2);

endmodule

// File: rtl/uart_recv_cfg.sv
// Configurable UART receiver: frame FSM, bit timer, shift register, holding register.
// Define UART_RECV_PARITY_EN to add a parity bit after the data bits.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge
// START  | checking the start bit, aborts on a false start
// DATA   | shifting in DATA_BITS bits, LSB first
// PARITY | checking the parity bit (parity builds only)
// STOP   | checking STOP_BITS stop bits, commits at the last one
module uart_recv_cfg
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50000000,
   parameter int UART_BPS   = 115200,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic            sys_clk,
   input  logic            sys_rst,
   input  logic            uart_rxd,
   output logic            rx_busy,
   uart_recv_cfg_if.master rx_if
);

   localparam int BPS_CNT = bps_cnt(CLK_FREQ, UART_BPS);
   localparam int CNT_W   = $clog2(BPS_CNT);
   localparam int M       = BPS_CNT / 2;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);
   localparam logic [CNT_W-1:0] CNT_RES  = CNT_W'(M + SMP_LATE_OFS);
   localparam logic [3:0] IDX_LAST_DATA  = 4'(DATA_BITS - 1);
   localparam logic [3:0] IDX_LAST_STOP  = 4'(STOP_BITS - 1);
`ifdef UART_RECV_PARITY_EN
   localparam bit PAR_ODD = (PARITY_ODD != 0);
`else
   localparam bit par_odd_unused = (PARITY_ODD != 0);
`endif

   uart_rx_state_t       state_q, state_nxt;
   logic [CNT_W-1:0]     clk_cnt, cnt_nxt;
   logic [3:0]           idx_q, idx_nxt;
   logic [DATA_BITS-1:0] shift_q, shift_nxt;
   logic                 ferr_q, ferr_nxt, perr_q, perr_nxt, commit;
   logic                 fall_edge, bit_val, at_res, at_end;
   logic                 rxd_s_unused;

   logic [DATA_BITS-1:0] data_q;
   logic                 valid_q, ferr_h, perr_h, ovr_q;

   uart_rx_sync_filter #(.CNT_W(CNT_W), .M(M)) u_filter (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .uart_rxd  (uart_rxd),
      .clk_cnt   (clk_cnt),
      .rxd_s     (rxd_s_unused),
      .fall_edge (fall_edge),
      .bit_val   (bit_val)
   );

   assign at_res = (clk_cnt == CNT_RES);
   assign at_end = (clk_cnt == CNT_LAST);

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q <= IDLE;
         clk_cnt <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         ferr_q  <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_nxt;
         clk_cnt <= cnt_nxt;
         idx_q   <= idx_nxt;
         shift_q <= shift_nxt;
         ferr_q  <= ferr_nxt;
         perr_q  <= perr_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = (state_q == IDLE || at_end) ? '0 : clk_cnt + 1'b1;
      idx_nxt   = idx_q;
      shift_nxt = shift_q;
      ferr_nxt  = ferr_q;
      perr_nxt  = perr_q;
      commit    = 1'b0;
      case (state_q)
         IDLE: begin
            if (fall_edge) begin
               state_nxt = START;
               idx_nxt   = '0;
               ferr_nxt  = 1'b0;
               perr_nxt  = 1'b0;
            end
         end
         START: begin
            if (at_res && bit_val) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (at_end) begin
               state_nxt = DATA;
            end
         end
         DATA: begin
            if (at_res) shift_nxt = {bit_val, shift_q[DATA_BITS-1:1]};
            if (at_end) begin
               if (idx_q == IDX_LAST_DATA) begin
                  idx_nxt = '0;
`ifdef UART_RECV_PARITY_EN
                  state_nxt = PARITY;
`else
                  state_nxt = STOP;
`endif
               end else begin
                  idx_nxt = idx_q + 1'b1;
               end
            end
         end
`ifdef UART_RECV_PARITY_EN
         PARITY: begin
            if (at_res) perr_nxt = bit_val ^ (^shift_q) ^ PAR_ODD;
            if (at_end) state_nxt = STOP;
         end
`endif
         STOP: begin
            // The last stop bit commits at its centre so a back-to-back start edge is not missed.
            if (at_res) begin
               if (!bit_val) ferr_nxt = 1'b1;
               if (idx_q == IDX_LAST_STOP) begin
                  commit    = 1'b1;
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
               end
            end else if (at_end) begin
               idx_nxt = idx_q + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_h  <= 1'b0;
         perr_h  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         ovr_q <= commit & valid_q & ~rx_if.rx_ready;
         if (commit) begin
            data_q  <= shift_q;
            ferr_h  <= ferr_nxt;
            perr_h  <= perr_q;
            valid_q <= 1'b1;
         end else if (valid_q && rx_if.rx_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign rx_if.rx_data       = data_q;
   assign rx_if.rx_valid      = valid_q;
   assign rx_if.rx_frame_err  = ferr_h;
   assign rx_if.rx_parity_err = perr_h;
   assign rx_if.rx_overrun    = ovr_q;
   assign rx_busy             = (state_q != IDLE);

endmodule

// File: tb/tb_uart_recv_cfg.sv
// Self-checking bench for uart_recv_cfg: an 8N1 instance at 434 clocks/bit and a
// 7-bit, 2-stop, odd-parity instance at 16 clocks/bit, checked through scoreboards.
module tb_uart_recv_cfg;

`ifdef UART_RECV_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif
   localparam int BPS8 = 434;
   localparam int BPS7 = 16;

   logic sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   logic rst8 = 1'b1, rst7 = 1'b1;
   logic rxd8 = 1'b1, rxd7 = 1'b1;
   logic busy8, busy7;

   uart_recv_cfg_if #(.DATA_BITS(8)) if8 ();
   uart_recv_cfg_if #(.DATA_BITS(7)) if7 ();

   uart_recv_cfg #(.CLK_FREQ(50000000), .UART_BPS(115200), .DATA_BITS(8),
                   .STOP_BITS(1), .PARITY_ODD(0)) dut8 (
      .sys_clk(sys_clk), .sys_rst(rst8), .uart_rxd(rxd8), .rx_busy(busy8), .rx_if(if8));

   uart_recv_cfg #(.CLK_FREQ(1600000), .UART_BPS(100000), .DATA_BITS(7),
                   .STOP_BITS(2), .PARITY_ODD(1)) dut7 (
      .sys_clk(sys_clk), .sys_rst(rst7), .uart_rxd(rxd7), .rx_busy(busy7), .rx_if(if7));

   typedef struct packed {
      logic [8:0] data;
      logic       ferr;
      logic       perr;
   } exp_t;

   typedef struct {
      logic [6:0] data;
      logic       s1;
      logic       s2;
      logic       pflip;
      logic       exp_ferr;
   } vec_t;

   exp_t q8[$];
   exp_t q7[$];
   exp_t e8, e7;
   int   errors = 0, checks = 0;
   int   vcnt8 = 0, ovr8 = 0;
   vec_t tbl[6];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic push(input int ln, input logic [8:0] d, input logic f, input logic p);
      exp_t e;
      e.data = d;
      e.ferr = f;
      e.perr = p;
      if (ln == 0) q8.push_back(e);
      else q7.push_back(e);
   endtask

   function automatic logic par_of(input logic [8:0] d, input int n);
      logic p;
      p = 1'b0;
      for (int i = 0; i < n; i++) p ^= d[i];
      return p;
   endfunction

   task automatic drive_bit(input int ln, input logic v);
      if (ln == 0) begin
         rxd8 = v;
         repeat (BPS8) tick();
      end else begin
         rxd7 = v;
         repeat (BPS7) tick();
      end
   endtask

   task automatic send_frame(input int ln, input logic [8:0] d, input int nbits, input bit odd,
                             input bit pflip, input int nstop, input logic s1, input logic s2);
      drive_bit(ln, 1'b0);
      for (int i = 0; i < nbits; i++) drive_bit(ln, d[i]);
      if (PAR_EN) drive_bit(ln, par_of(d, nbits) ^ odd ^ pflip);
      drive_bit(ln, s1);
      if (nstop == 2) drive_bit(ln, s2);
   endtask

   task automatic idle(input int ln, input int nbits);
      for (int i = 0; i < nbits; i++) drive_bit(ln, 1'b1);
   endtask

   task automatic drain(input int ln, input string nm);
      int n;
      n = 0;
      while (((ln == 0) ? q8.size() : q7.size()) != 0 && n < 200) begin
         tick();
         n++;
      end
      check(nm, 32'((ln == 0) ? q8.size() : q7.size()), 32'd0);
   endtask

   // Scoreboards: a transfer is seen between edges, before the edge that consumes it.
   always @(negedge sys_clk) begin
      if (if8.rx_valid) vcnt8++;
      if (if8.rx_overrun) ovr8++;
      if (if8.rx_valid && if8.rx_ready) begin
         check("sb8_expected", 32'(q8.size() > 0), 32'd1);
         if (q8.size() > 0) begin
            e8 = q8.pop_front();
            check("sb8_data", 32'(if8.rx_data), 32'(e8.data));
            check("sb8_ferr", 32'(if8.rx_frame_err), 32'(e8.ferr));
            check("sb8_perr", 32'(if8.rx_parity_err), 32'(e8.perr));
         end
      end
   end

   always @(negedge sys_clk) begin
      if (if7.rx_valid && if7.rx_ready) begin
         check("sb7_expected", 32'(q7.size() > 0), 32'd1);
         if (q7.size() > 0) begin
            e7 = q7.pop_front();
            check("sb7_data", 32'(if7.rx_data), 32'(e7.data));
            check("sb7_ferr", 32'(if7.rx_frame_err), 32'(e7.ferr));
            check("sb7_perr", 32'(if7.rx_parity_err), 32'(e7.perr));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int v0, o0;
      tbl[0] = '{7'h7F, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{7'h00, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{7'h2A, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[3] = '{7'h15, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[4] = '{7'h41, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[5] = '{7'h33, 1'b1, 1'b1, 1'b0, 1'b0};

      if8.rx_ready = 1'b1;
      if7.rx_ready = 1'b1;
      repeat (3) tick();
      check("rst_valid", 32'(if8.rx_valid), 32'd0);
      check("rst_data", 32'(if8.rx_data), 32'd0);
      check("rst_ferr", 32'(if8.rx_frame_err), 32'd0);
      check("rst_perr", 32'(if8.rx_parity_err), 32'd0);
      check("rst_ovr", 32'(if8.rx_overrun), 32'd0);
      check("rst_busy", 32'(busy8), 32'd0);
      rst8 = 1'b0;
      rst7 = 1'b0;
      repeat (2) tick();

      // Plain 0x55 with the consumer always ready
      v0 = vcnt8;
      push(0, 9'h055, 1'b0, 1'b0);
      send_frame(0, 9'h055, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
      idle(0, 2);
      drain(0, "t55_drain");
      check("t55_valid_cycles", 32'(vcnt8 - v0), 32'd1);

      // 100-cycle glitch must be rejected at the start-bit sample
      v0 = vcnt8;
      rxd8 = 1'b0;
      repeat (50) tick();
      check("fs_busy_mid", 32'(busy8), 32'd1);
      repeat (50) tick();
      rxd8 = 1'b1;
      repeat (200) tick();
      check("fs_idle", 32'(busy8), 32'd0);
      check("fs_no_valid", 32'(vcnt8 - v0), 32'd0);

`ifdef UART_RECV_PARITY_EN
      push(0, 9'h0A3, 1'b0, 1'b1);
      send_frame(0, 9'h0A3, 8, 1'b0, 1'b1, 1, 1'b1, 1'b1);
      idle(0, 2);
      drain(0, "par_drain");
`endif

      // Bad stop bit, then a clean frame clears the flag
      push(0, 9'h03C, 1'b1, 1'b0);
      send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b0, 1'b1);
      idle(0, 2);
      push(0, 9'h001, 1'b0, 1'b0);
      send_frame(0, 9'h001, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
      idle(0, 2);
      drain(0, "ferr_drain");

      // Back-to-back frames with the consumer stalled
      if8.rx_ready = 1'b0;
      o0 = ovr8;
      send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
      send_frame(0, 9'h022, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
      idle(0, 2);
      check("ovr_pulses", 32'(ovr8 - o0), 32'd1);
      check("ovr_data", 32'(if8.rx_data), 32'h22);
      check("ovr_valid", 32'(if8.rx_valid), 32'd1);
      push(0, 9'h022, 1'b0, 1'b0);
      if8.rx_ready = 1'b1;
      drain(0, "ovr_drain");
      tick();
      check("ovr_valid_clr", 32'(if8.rx_valid), 32'd0);

      // Break: one all-zero frame with a frame error, then silence
      v0 = vcnt8;
      push(0, 9'h000, 1'b1, 1'b0);
      rxd8 = 1'b0;
      repeat ((10 + int'(PAR_EN) + 3) * BPS8) tick();
      drain(0, "brk_drain");
      check("brk_one_word", 32'(vcnt8 - v0), 32'd1);
      check("brk_idle", 32'(busy8), 32'd0);
      idle(0, 2);

      // 7-bit, two stop bits, odd parity: table of frames
      for (int i = 0; i < 6; i++) begin
         push(1, {2'b00, tbl[i].data}, tbl[i].exp_ferr, tbl[i].pflip & PAR_EN);
         send_frame(1, {2'b00, tbl[i].data}, 7, 1'b1, tbl[i].pflip, 2, tbl[i].s1, tbl[i].s2);
         idle(1, 2);
      end
      drain(1, "tbl_drain");

      // Reset mid-frame drops both the held word and the partial frame
      if7.rx_ready = 1'b0;
      send_frame(1, 9'h055, 7, 1'b1, 1'b0, 2, 1'b1, 1'b1);
      idle(1, 2);
      check("rst7_held", 32'(if7.rx_valid), 32'd1);
      drive_bit(1, 1'b0);
      drive_bit(1, 1'b1);
      drive_bit(1, 1'b1);
      drive_bit(1, 1'b0);
      rxd7 = 1'b0;
      repeat (BPS7 / 2) tick();
      rst7 = 1'b1;
      rxd7 = 1'b1;
      tick();
      check("rst7_valid", 32'(if7.rx_valid), 32'd0);
      check("rst7_data", 32'(if7.rx_data), 32'd0);
      check("rst7_ferr", 32'(if7.rx_frame_err), 32'd0);
      check("rst7_perr", 32'(if7.rx_parity_err), 32'd0);
      check("rst7_ovr", 32'(if7.rx_overrun), 32'd0);
      check("rst7_busy", 32'(busy7), 32'd0);
      rst7 = 1'b0;
      if7.rx_ready = 1'b1;
      idle(1, 6);
      check("rst7_quiet_valid", 32'(if7.rx_valid), 32'd0);
      check("rst7_quiet_busy", 32'(busy7), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_recv_cfg.md
# uart_recv_cfg

Parametrised UART receiver, the successor to the fixed 8N1 receiver in the `_02_Drive/uart` driver layer. Data width, stop-bit count and parity are configurable. Each bit is sampled three times around its centre and resolved by majority vote. The block rejects false start bits and flags framing errors, parity errors and overruns. Received words are delivered over a valid/ready interface with a one-entry holding register, so command parsers downstream do not need to capture a single-cycle pulse.

## Interface
- CLK_FREQ, 50000000, system clock frequency in Hz
- UART_BPS, 115200, baud rate; BPS_CNT = CLK_FREQ/UART_BPS, must be ≥ 8
- DATA_BITS, 8, data bits per frame, legal range 5..9
- STOP_BITS, 1, stop bits checked, 1 or 2
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; only used with UART_RECV_PARITY_EN
- sys_clk  in  1  system clock; all logic on its rising edge
- sys_rst  in  1  reset; synchronous, active-high
- uart_rxd  in  1  asynchronous serial input, idle high
- rx_data  out  DATA_BITS  received word, LSB first on the line; valid while rx_valid=1
- rx_valid  out  1  holding register full
- rx_ready  in  1  consumer accepts; a transfer occurs when rx_valid && rx_ready
- rx_frame_err  out  1  stop bit sampled 0; qualified by rx_valid
- rx_parity_err  out  1  parity mismatch; qualified by rx_valid; tied 0 when parity is compiled out
- rx_overrun  out  1  one-cycle pulse: a frame completed while the holding register was full and not being read
- rx_busy  out  1  state ≠ IDLE

## Operation
- Input synchroniser: uart_rxd passes through a 2-FF synchroniser to give rxd_s. Both flops reset to 1. Falling edge = previous rxd_s is 1 and current rxd_s is 0.
- Bit counter clk_cnt has width $clog2(BPS_CNT). It counts 0..BPS_CNT-1 within each bit period.
- Three samples are taken at clk_cnt = M-1, M and M+1, where M = BPS_CNT/2. The bit value is the majority of the three samples and is resolved at M+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a falling edge, go to START with clk_cnt=0.
  - START: if the resolved bit is 1, this is a false start: go to IDLE with no outputs. If 0, continue and go to DATA at the bit boundary.
  - DATA: shift the resolved bits in LSB first. After DATA_BITS bits, go to PARITY if parity is compiled in, otherwise go to STOP.
  - PARITY: compare the resolved bit against the XOR of the data bits, XORed with PARITY_ODD. The result is the parity error.
  - STOP: resolve each of the STOP_BITS stop bits. Any stop bit that resolves to 0 sets the frame error. At the M+1 resolution of the last stop bit, commit the frame and go to IDLE in the same cycle, without waiting for the end of the bit period.
- Commit: load rx_data, rx_frame_err and rx_parity_err, then set rx_valid.
  - Frames with errors are still delivered, with their flags set.
  - If rx_valid=1 and rx_ready=0 at commit: overwrite the register with the new frame and pulse rx_overrun.
  - If rx_ready=1 in the commit cycle: the old word is consumed and the new word is loaded. No overrun.
- rx_valid clears on a transfer with no commit in the same cycle.
- Line held at 0 (break): a frame of all zeros is committed with rx_frame_err=1. IDLE then waits for a fresh falling edge, so no further frames are produced until the line returns high.

## Timing
- Reset values: rx_data=0, rx_valid=0, rx_frame_err=0, rx_parity_err=0, rx_overrun=0, rx_busy=0. FSM = IDLE, clk_cnt=0.
- Reset asserted mid-frame: FSM returns to IDLE on the next edge. Any held word and the partial frame are discarded.
- rx_valid rises 1 cycle after the M+1 sample of the last stop bit.
- The synchroniser adds 2 cycles of latency from the line.
- rx_valid and rx_data are stable until transfer or overwrite.
- Minimum inter-frame gap: none. A start edge arriving during the second half of the last stop bit is detected.

## Configuration
- UART_RECV_PARITY_EN defined:
  - The PARITY state exists.
  - A frame is 1 + DATA_BITS + 1 + STOP_BITS bit periods long.
  - rx_parity_err is live.
- Not defined:
  - There is no PARITY state; DATA goes directly to STOP.
  - rx_parity_err is tied 0.
  - PARITY_ODD is ignored.

## Structure
- Package uart_pkg:
  - FSM state enum uart_rx_state_t.
  - Function bps_cnt(clk_freq, bps).
  - Localparams for the sample offsets (M-1, M, M+1).
- Sub-module uart_rx_sync_filter:
  - 2-FF synchroniser, falling-edge detect and 3-sample majority vote.
  - Outputs rxd_s, fall_edge and bit_val.
- Top level: FSM, counters, shift register and holding register.

## Test plan
- CLK_FREQ=50e6, UART_BPS=115200, 8N1, send 0x55 with rx_ready=1 → rx_data=0x55, rx_valid=1 for one cycle, both error flags 0.
- 0-pulse of 100 cycles on an idle line (BPS_CNT=434) → FSM returns to IDLE at the START sample, rx_valid stays 0.
- UART_RECV_PARITY_EN with PARITY_ODD=0, send 0xA3 with parity bit 1 (correct is 0) → rx_data=0xA3, rx_parity_err=1.
- Send 0x3C with stop bit forced 0 → rx_data=0x3C, rx_frame_err=1. Next frame 0x01 with a good stop bit → rx_frame_err=0.
- rx_ready=0, send 0x11 then 0x22 back-to-back → rx_overrun pulses once at the second commit, rx_data=0x22.
- DATA_BITS=7, STOP_BITS=2, send 0x7F → rx_data=0x7F. sys_rst pulsed mid-bit-3 of the next frame → all outputs 0, FSM IDLE, no spurious rx_valid.
